// File: rtl/calc_pkg.sv
// Shared calculator types: divider FSM state encoding and default sizing.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int DIV_DATA_W = 8;
  localparam int DIV_CNT_W  = $clog2(DIV_DATA_W);

endpackage

// File: rtl/full_sub_wborrow_nbits.sv
// N-bit subtractor a - b - bin with difference and borrow-out.
module full_sub_wborrow_nbits #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             cout_o
);

  logic [WIDTH:0] w_full;

  // The extra top bit goes to 1 exactly when a < b + bin.
  assign w_full = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, bin_i};
  assign diff_o = w_full[WIDTH-1:0];
  assign cout_o = w_full[WIDTH];

endmodule

// File: rtl/seq_restoring_divider.sv
// Restoring divider, one quotient bit per clock.
// Define CALC_DIV_SIGNED_EN for two's-complement operands (adds the FIX state).
module seq_restoring_divider
  import calc_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o,
  output logic              div_by_zero_o,
  output logic              overflow_o
);

  localparam int CNT_W = $clog2(DATA_W);

  function automatic logic [DATA_W-1:0] twos_neg(input logic [DATA_W-1:0] v);
    return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  div_state_t        r_state;
  div_state_t        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_dvd;
  logic [DATA_W-1:0] r_dvs;
  logic              w_start;
  logic              w_dvs_zero;
  logic [DATA_W:0]   w_shift;
  logic [DATA_W:0]   w_diff;
  logic              w_borrow;
  logic [DATA_W-1:0] w_rem_nxt;
  logic [DATA_W-1:0] w_quo_nxt;
  logic [DATA_W-1:0] w_a_mag;
  logic [DATA_W-1:0] w_b_mag;
  logic              w_unused_msb;

  assign w_start    = start_i && (r_state == IDLE || r_state == DONE);
  assign w_dvs_zero = (divisor_i == '0);
  assign busy_o     = (r_state == CALC) || (r_state == FIX);
  assign done_o     = (r_state == DONE);

`ifdef CALC_DIV_SIGNED_EN
  logic signed [DATA_W-1:0] w_a_s;
  logic signed [DATA_W-1:0] w_b_s;
  logic                     r_sign_q;
  logic                     r_sign_r;
  logic                     r_ovf;

  assign w_a_s   = dividend_i;
  assign w_b_s   = divisor_i;
  assign w_a_mag = (w_a_s < 0) ? twos_neg(dividend_i) : dividend_i;
  assign w_b_mag = (w_b_s < 0) ? twos_neg(divisor_i) : divisor_i;
`else
  assign w_a_mag    = dividend_i;
  assign w_b_mag    = divisor_i;
  assign overflow_o = 1'b0;
`endif

  // p0: shift next dividend bit into the partial remainder and trial-subtract
  assign w_shift = {r_rem, r_dvd[DATA_W-1]};

  full_sub_wborrow_nbits #(
    .WIDTH(DATA_W + 1)
  ) u_sub (
    .a_i   (w_shift),
    .b_i   ({1'b0, r_dvs}),
    .bin_i (1'b0),
    .diff_o(w_diff),
    .cout_o(w_borrow)
  );

  // A kept difference is always below the divisor, so its top bit is zero.
  assign w_unused_msb = w_diff[DATA_W];
  assign w_rem_nxt    = w_borrow ? w_shift[DATA_W-1:0] : w_diff[DATA_W-1:0];
  assign w_quo_nxt    = {r_dvd[DATA_W-2:0], ~w_borrow};

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, DONE: begin
        if (start_i) w_state_nxt = w_dvs_zero ? DONE : CALC;
        else         w_state_nxt = IDLE;
      end
      CALC: begin
`ifdef CALC_DIV_SIGNED_EN
        if (r_cnt == '0) w_state_nxt = FIX;
`else
        if (r_cnt == '0) w_state_nxt = DONE;
`endif
      end
      FIX:     w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // p1: control state, counter and the architecturally visible results
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      quotient_o    <= '0;
      remainder_o   <= '0;
      div_by_zero_o <= 1'b0;
`ifdef CALC_DIV_SIGNED_EN
      overflow_o    <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_cnt         <= CNT_W'(DATA_W - 1);
        div_by_zero_o <= w_dvs_zero;
`ifdef CALC_DIV_SIGNED_EN
        overflow_o    <= 1'b0;
`endif
        if (w_dvs_zero) begin
          quotient_o  <= '1;
          remainder_o <= dividend_i;
        end
      end else if (r_state == CALC) begin
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
`ifndef CALC_DIV_SIGNED_EN
        if (r_cnt == '0) begin
          quotient_o  <= w_quo_nxt;
          remainder_o <= w_rem_nxt;
        end
`endif
      end
`ifdef CALC_DIV_SIGNED_EN
      else if (r_state == FIX) begin
        quotient_o  <= r_sign_q ? twos_neg(r_dvd) : r_dvd;
        remainder_o <= r_sign_r ? twos_neg(r_rem) : r_rem;
        overflow_o  <= r_ovf;
      end
`endif
    end
  end

  // p2: iteration datapath, no reset needed since start reloads everything
  always_ff @(posedge clk_i) begin
    if (w_start) begin
      r_rem <= '0;
      r_dvd <= w_a_mag;
      r_dvs <= w_b_mag;
`ifdef CALC_DIV_SIGNED_EN
      r_sign_q <= dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1];
      r_sign_r <= dividend_i[DATA_W-1];
      r_ovf    <= (dividend_i == {1'b1, {(DATA_W-1){1'b0}}}) && (divisor_i == '1);
`endif
    end else if (r_state == CALC) begin
      r_rem <= w_rem_nxt;
      r_dvd <= w_quo_nxt;
    end
  end

endmodule
